cv32e41p_obi_stall_responder: RTL and testbench

//  Single-port OBI memory responder for the core testbench: the subordinate end of the core's instr/data request bus.

---
 rtl/cv32e41p_obi_stall_responder.sv | 112 +++++++++++
 tb/tb_cv32e41p_obi_stall_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41p_obi_stall_responder.sv
// Purpose     : OBI subordinate memory model with pseudo-random grant stalls, fixed
//               response latency and a bounded number of outstanding requests.
// Latency     : rvalid_o rises RVALID_LATENCY cycles after the granting edge (1 = next cycle).
// Backpressure: gnt_o drops on an LFSR stall or when MAX_OUTSTANDING requests are in
//               flight; a response retiring this cycle frees its slot for a same-cycle grant.
//               rvalid_o is never back-pressured.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   stall_en_i             enables pseudo-random grant stalls (~25 %)
//   req_i / gnt_o          OBI request / grant; accepted when both are high
//   addr_i, we_i, be_i,    byte address (only [RAM_ADDR_WIDTH-1:2] decoded), write enable,
//   wdata_i                byte-lane enables, write data
//   rvalid_o, rdata_o      in-order response pulse and read data (0 for writes / idle)
//   outstanding_o          granted-but-unanswered request count
module cv32e41p_obi_stall_responder #(
   parameter int unsigned RAM_ADDR_WIDTH  = 20,
   parameter int unsigned RVALID_LATENCY  = 1,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_en_i,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic [3:0]  outstanding_o
);

   localparam int unsigned WORDS = 2 ** (RAM_ADDR_WIDTH - 2);

   logic [31:0]               mem [WORDS];
   logic [RAM_ADDR_WIDTH-3:0] word_idx;

   logic [15:0] lfsr;
   logic        lfsr_fb;
   logic        stall;

   logic [RVALID_LATENCY-1:0] pipe_vld;
   logic [31:0]               pipe_dat [RVALID_LATENCY];

   logic [3:0] count;
   logic       retire;
   logic       accept;

   // Bits above the decoded window alias; the byte offset within a word is irrelevant.
   logic unused_addr;
   assign unused_addr = ^{addr_i[31:RAM_ADDR_WIDTH], addr_i[1:0]};

   assign word_idx = addr_i[RAM_ADDR_WIDTH-1:2];

   // x^16 + x^14 + x^13 + x^11 + 1, shifting left with feedback into bit 0.
   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign stall   = stall_en_i & (lfsr[1:0] == 2'b00);

   // The oldest pipeline stage is the response being presented this cycle.
   assign retire = pipe_vld[RVALID_LATENCY-1];

   // rst_ni is folded in so the grant is held low during reset.
   assign gnt_o  = rst_ni & ~stall & ((count < 4'(MAX_OUTSTANDING)) | retire);
   assign accept = req_i & gnt_o;

   assign rvalid_o      = pipe_vld[RVALID_LATENCY-1];
   assign rdata_o       = pipe_dat[RVALID_LATENCY-1];
   assign outstanding_o = count;

   // Control state: LFSR, response pipeline and outstanding counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr     <= LFSR_SEED;
         pipe_vld <= '0;
         count    <= '0;
         for (int i = 0; i < RVALID_LATENCY; i++) begin
            pipe_dat[i] <= '0;
         end
      end else begin
         lfsr <= {lfsr[14:0], lfsr_fb};

         // Stage 0 captures the read word at grant time; writes and idle slots carry 0
         // so rdata_o is zero whenever rvalid_o is low.
         pipe_vld[0] <= accept;
         pipe_dat[0] <= (accept & ~we_i) ? mem[word_idx] : 32'h0;
         for (int i = 1; i < RVALID_LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_dat[i] <= pipe_dat[i-1];
         end

         case ({accept, retire})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
      end
   end

   // RAM has no reset so its contents survive a core reset.
   always_ff @(posedge clk_i) begin
      if (accept & we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_cv32e41p_obi_stall_responder.sv
// Bench for cv32e41p_obi_stall_responder: instance "dut" uses latency 1, instance "dut_b"
// uses latency 3 with a small RAM; both allow two outstanding requests.
module tb_cv32e41p_obi_stall_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // latency-1 instance
   logic        rst_n, stall_en, req, gnt, we, rvalid;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be, outst;

   // latency-3 instance
   logic        rst_n_b, stall_en_b, req_b, gnt_b, we_b, rvalid_b;
   logic [31:0] addr_b, wdata_b, rdata_b;
   logic [3:0]  be_b, outst_b;

   cv32e41p_obi_stall_responder #(
      .RAM_ADDR_WIDTH(20), .RVALID_LATENCY(1), .MAX_OUTSTANDING(2), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .stall_en_i(stall_en), .req_i(req), .gnt_o(gnt),
      .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid),
      .rdata_o(rdata), .outstanding_o(outst)
   );

   cv32e41p_obi_stall_responder #(
      .RAM_ADDR_WIDTH(12), .RVALID_LATENCY(3), .MAX_OUTSTANDING(2), .LFSR_SEED(16'hACE1)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n_b), .stall_en_i(stall_en_b), .req_i(req_b), .gnt_o(gnt_b),
      .addr_i(addr_b), .we_i(we_b), .be_i(be_b), .wdata_i(wdata_b), .rvalid_o(rvalid_b),
      .rdata_o(rdata_b), .outstanding_o(outst_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: word-indexed memory plus a FIFO of expected responses in grant order.
   logic [31:0] model_mem [int];
   logic [31:0] exp_q [$];
   logic [31:0] pre_b [3];

   task automatic model_accept(input logic w, input logic [31:0] a, input logic [3:0] b,
                               input logic [31:0] d);
      int          idx;
      logic [31:0] cur;
      idx = int'((a & 32'h000F_FFFF) >> 2);
      if (w) begin
         cur = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
         for (int k = 0; k < 4; k++) begin
            if (b[k]) cur[8*k +: 8] = d[8*k +: 8];
         end
         model_mem[idx] = cur;
         exp_q.push_back(32'h0);
      end else begin
         exp_q.push_back(model_mem[idx]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rst_n_b = 1'b0;
      stall_en = 1'b0; stall_en_b = 1'b0;
      req = 1'b1; req_b = 1'b1;
      we = 1'b0; we_b = 1'b0; be = 4'h0; be_b = 4'h0;
      addr = '0; addr_b = '0; wdata = '0; wdata_b = '0;
      repeat (2) @(negedge clk);
      n_tests++; if (gnt !== 1'b0)      begin n_fail++; $display("FAIL reset_gnt got %b want 0", gnt); end
      n_tests++; if (rvalid !== 1'b0)   begin n_fail++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
      n_tests++; if (rdata !== 32'h0)   begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
      n_tests++; if (outst !== 4'd0)    begin n_fail++; $display("FAIL reset_outst got %0d want 0", outst); end
      n_tests++; if (gnt_b !== 1'b0)    begin n_fail++; $display("FAIL reset_gnt_b got %b want 0", gnt_b); end
      n_tests++; if (rvalid_b !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_b got %b want 0", rvalid_b); end
      n_tests++; if (outst_b !== 4'd0)  begin n_fail++; $display("FAIL reset_outst_b got %0d want 0", outst_b); end
      @(posedge clk); #1;
      req = 1'b0; req_b = 1'b0;
      rst_n = 1'b1; rst_n_b = 1'b1;
      @(negedge clk);
      n_tests++; if (gnt !== 1'b1)    begin n_fail++; $display("FAIL post_reset_gnt got %b want 1", gnt); end
      n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL post_reset_rvalid got %b want 0", rvalid); end
      n_tests++; if (outst !== 4'd0)  begin n_fail++; $display("FAIL post_reset_outst got %0d want 0", outst); end
   endtask

   // Back-to-back directed writes/reads: lane merge, read-after-write, read ignoring be, alias.
   task automatic test_directed();
      logic        r_we   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] r_addr [6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h0010_0100, 32'h100};
      logic [3:0]  r_be   [6] = '{4'hF, 4'hF, 4'b0101, 4'h0, 4'hF, 4'hF};
      logic [31:0] r_wd   [6] = '{32'h1234_5678, 32'h0, 32'hAABB_CCDD, 32'h0, 32'hCAFE_F00D, 32'h0};
      logic [31:0] r_exp  [6] = '{32'h0, 32'h1234_5678, 32'h0, 32'h12BB_56DD, 32'h0, 32'hCAFE_F00D};
      for (int i = 0; i <= 6; i++) begin
         @(posedge clk); #1;
         if (i < 6) begin
            req = 1'b1; we = r_we[i]; addr = r_addr[i]; be = r_be[i]; wdata = r_wd[i];
         end else begin
            req = 1'b0;
         end
         @(negedge clk);
         if (i < 6) begin
            n_tests++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL dir_gnt row%0d got %b want 1", i, gnt); end
         end
         if (i == 0) begin
            n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL dir_rvalid row%0d got %b want 0", i, rvalid); end
            n_tests++; if (outst !== 4'd0)  begin n_fail++; $display("FAIL dir_outst row%0d got %0d want 0", i, outst); end
         end else begin
            n_tests++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL dir_rvalid row%0d got %b want 1", i - 1, rvalid); end
            n_tests++; if (rdata !== r_exp[i-1]) begin n_fail++; $display("FAIL dir_rdata row%0d got %h want %h", i - 1, rdata, r_exp[i-1]); end
            n_tests++; if (outst !== 4'd1)  begin n_fail++; $display("FAIL dir_outst row%0d got %0d want 1", i, outst); end
         end
      end
      // Keep the model aware of what the directed rows left in RAM.
      model_mem[32'h100 >> 2] = 32'hCAFE_F00D;
   endtask

   // Latency 3, two outstanding, three reads held from cycle 0.
   task automatic test_pipeline();
      int g_cyc [3] = '{0, 1, 3};
      int r_cyc [3] = '{3, 4, 6};
      int g = 0;
      int ri = 0;
      int exp_out;
      logic exp_rv;
      for (int k = 0; k < 3; k++) begin
         pre_b[k] = 32'h5A00_0000 + 32'($urandom_range(0, 32'hFFFF)) + (32'(k) << 16);
         @(posedge clk); #1;
         req_b = 1'b1; we_b = 1'b1; addr_b = 32'(k * 4); be_b = 4'hF; wdata_b = pre_b[k];
         @(negedge clk);
         n_tests++; if (gnt_b !== 1'b1) begin n_fail++; $display("FAIL pre_gnt_b k%0d got %b want 1", k, gnt_b); end
         @(posedge clk); #1;
         req_b = 1'b0; we_b = 1'b0;
         repeat (4) @(posedge clk);
      end
      @(negedge clk);
      n_tests++; if (outst_b !== 4'd0) begin n_fail++; $display("FAIL pre_outst_b got %0d want 0", outst_b); end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         req_b = (g < 3); we_b = 1'b0; be_b = 4'h0; addr_b = 32'(g * 4);
         @(negedge clk);
         if (c <= 3) begin
            n_tests++; if (gnt_b !== (c != 2)) begin n_fail++; $display("FAIL pipe_gnt cyc%0d got %b want %b", c, gnt_b, (c != 2)); end
         end
         exp_rv = (c == r_cyc[0]) || (c == r_cyc[1]) || (c == r_cyc[2]);
         n_tests++; if (rvalid_b !== exp_rv) begin n_fail++; $display("FAIL pipe_rvalid cyc%0d got %b want %b", c, rvalid_b, exp_rv); end
         if (exp_rv) begin
            n_tests++; if (rdata_b !== pre_b[ri]) begin n_fail++; $display("FAIL pipe_rdata cyc%0d got %h want %h", c, rdata_b, pre_b[ri]); end
            ri++;
         end else begin
            n_tests++; if (rdata_b !== 32'h0) begin n_fail++; $display("FAIL pipe_rdata_idle cyc%0d got %h want 0", c, rdata_b); end
         end
         exp_out = 0;
         for (int k = 0; k < 3; k++) begin
            if (g_cyc[k] < c) exp_out++;
            if (r_cyc[k] < c) exp_out--;
         end
         n_tests++; if (outst_b !== 4'(exp_out)) begin n_fail++; $display("FAIL pipe_outst cyc%0d got %0d want %0d", c, outst_b, exp_out); end
         if (req_b && gnt_b) g++;
      end
      req_b = 1'b0;
   endtask

   // Random traffic with stalls on the latency-1 instance.
   task automatic test_random();
      int          stalls = 0;
      int          idx;
      logic [31:0] e;
      stall_en = 1'b1;
      exp_q.delete();
      for (int c = 0; c < 1000; c++) begin
         @(posedge clk); #1;
         idx   = 32'h800 + $urandom_range(0, 15);
         req   = ($urandom_range(0, 3) != 0);
         we    = !model_mem.exists(idx) || ($urandom_range(0, 1) == 1);
         addr  = {12'($urandom), 18'(idx), 2'($urandom)};
         be    = 4'($urandom);
         wdata = $urandom;
         @(negedge clk);
         if (!gnt) stalls++;
         n_tests++; if (outst !== 4'(exp_q.size())) begin n_fail++; $display("FAIL rnd_outst cyc%0d got %0d want %0d", c, outst, exp_q.size()); end
         n_tests++; if (gnt && !(exp_q.size() < 2 || rvalid)) begin n_fail++; $display("FAIL rnd_gnt_cap cyc%0d got gnt=1 want 0 (outst %0d)", c, exp_q.size()); end
         if (rvalid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rnd_spurious_rvalid cyc%0d got rvalid=1 want 0", c);
            end else begin
               e = exp_q.pop_front();
               if (rdata !== e) begin n_fail++; $display("FAIL rnd_rdata cyc%0d got %h want %h", c, rdata, e); end
            end
         end else begin
            n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rnd_rdata_idle cyc%0d got %h want 0", c, rdata); end
         end
         if (req && gnt) model_accept(we, addr, be, wdata);
      end
      @(posedge clk); #1;
      req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (rvalid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++; if (rdata !== e) begin n_fail++; $display("FAIL rnd_drain_rdata got %h want %h", rdata, e); end
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_missing_rvalid got %0d unanswered want 0", exp_q.size()); end
      n_tests++; if (outst !== 4'd0) begin n_fail++; $display("FAIL rnd_final_outst got %0d want 0", outst); end
      n_tests++; if (stalls < 200 || stalls > 300) begin n_fail++; $display("FAIL rnd_stall_ratio got %0d/1000 want 200..300", stalls); end
      stall_en = 1'b0;
   endtask

   // Reset pulse with two requests in flight on the latency-3 instance.
   task automatic test_reset_midflight();
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         req_b = 1'b1; we_b = 1'b0; addr_b = 32'(k * 4); be_b = 4'hF;
         @(negedge clk);
         n_tests++; if (gnt_b !== 1'b1) begin n_fail++; $display("FAIL mid_gnt k%0d got %b want 1", k, gnt_b); end
      end
      @(posedge clk); #1;
      req_b = 1'b0;
      n_tests++; if (outst_b !== 4'd2) begin n_fail++; $display("FAIL mid_outst_before got %0d want 2", outst_b); end
      #2 rst_n_b = 1'b0;
      #1;
      n_tests++; if (outst_b !== 4'd0) begin n_fail++; $display("FAIL mid_outst_async got %0d want 0", outst_b); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_tests++; if (rvalid_b !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid_in_reset cyc%0d got %b want 0", c, rvalid_b); end
         n_tests++; if (gnt_b !== 1'b0)    begin n_fail++; $display("FAIL mid_gnt_in_reset cyc%0d got %b want 0", c, gnt_b); end
      end
      @(posedge clk); #1;
      rst_n_b = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_tests++; if (rvalid_b !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid_after cyc%0d got %b want 0", c, rvalid_b); end
         n_tests++; if (outst_b !== 4'd0)  begin n_fail++; $display("FAIL mid_outst_after cyc%0d got %0d want 0", c, outst_b); end
      end
      @(posedge clk); #1;
      req_b = 1'b1; we_b = 1'b0; addr_b = 32'h0;
      @(negedge clk);
      n_tests++; if (gnt_b !== 1'b1) begin n_fail++; $display("FAIL mid_retain_gnt got %b want 1", gnt_b); end
      @(posedge clk); #1;
      req_b = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         n_tests++; if (rvalid_b !== (c == 3)) begin n_fail++; $display("FAIL mid_retain_rvalid cyc%0d got %b want %b", c, rvalid_b, (c == 3)); end
         if (c == 3) begin
            n_tests++; if (rdata_b !== pre_b[0]) begin n_fail++; $display("FAIL mid_retain_rdata got %h want %h", rdata_b, pre_b[0]); end
         end
         if (c < 3) @(posedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_pipeline();
      test_random();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got no completion want finish before 500000");
      $fatal(1, "timeout");
   end

endmodule
